// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, runs a single-outstanding request/response
// handshake with instruction memory and presents one instruction at a time to IF/ID.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pcWrite,
   input  logic        branchTaken,
   input  logic [31:0] branchTarget,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_o,
   output logic [31:0] pcPlusFour_o,
   output logic [31:0] inst_o,
   output logic        fetchValid_o
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] fetchPc_q, fetchPc_d;
   logic        discard_q, discard_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pcp4_q, pcp4_d;
   logic [31:0] inst_q, inst_d;
   logic        valid_q, valid_d;
   logic [31:0] fetchPcPlus4;

   assign fetchPcPlus4 = fetchPc_q + 32'd4;

   always_comb begin
      state_d   = state_q;
      fetchPc_d = fetchPc_q;
      discard_d = discard_q;
      pc_d      = pc_q;
      pcp4_d    = pcp4_q;
      inst_d    = inst_q;
      valid_d   = valid_q;

      case (state_q)
         S_REQ: begin
            if (imem_ready) begin
               state_d = S_WAIT;
               if (branchTaken) discard_d = 1'b1;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               state_d   = S_REQ;
               discard_d = 1'b0;
               if (!discard_q && !branchTaken) begin
                  state_d   = S_HOLD;
                  inst_d    = imem_rdata;
                  pc_d      = fetchPc_q;
                  pcp4_d    = fetchPcPlus4;
                  valid_d   = 1'b1;
                  fetchPc_d = fetchPcPlus4;
               end
            end else if (branchTaken) begin
               discard_d = 1'b1;
            end
         end
         S_HOLD: begin
            if (branchTaken) begin
               state_d = S_REQ;
            end else if (pcWrite) begin
               state_d = S_REQ;
               valid_d = 1'b0;
               inst_d  = '0;
            end
         end
         default: state_d = S_REQ;
      endcase

      // A redirect overrides whatever the state-specific logic chose for PC and outputs.
      if (branchTaken) begin
         fetchPc_d = {branchTarget[31:2], 2'b00};
         valid_d   = 1'b0;
         inst_d    = '0;
         pc_d      = '0;
         pcp4_d    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_REQ;
         fetchPc_q <= RESET_PC;
         discard_q <= 1'b0;
         pc_q      <= '0;
         pcp4_q    <= '0;
         inst_q    <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         fetchPc_q <= fetchPc_d;
         discard_q <= discard_d;
         pc_q      <= pc_d;
         pcp4_q    <= pcp4_d;
         inst_q    <= inst_d;
         valid_q   <= valid_d;
      end
   end

   assign imem_req     = (state_q == S_REQ) && !rst;
   assign imem_addr    = fetchPc_q;
   assign pc_o         = pc_q;
   assign pcPlusFour_o = pcp4_q;
   assign inst_o       = inst_q;
   assign fetchValid_o = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: transaction-level model (pending fetch, stale flag, presented
// instruction) plus a variable-latency memory, compared every cycle, with directed literal pins.
module tb_if_fetch_unit;

   localparam logic [31:0] RST_PC = 32'hFFFF_FFF4;

   logic        clk;
   logic        rst;
   logic        pcWrite;
   logic        branchTaken;
   logic [31:0] branchTarget;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] pc_o;
   logic [31:0] pcPlusFour_o;
   logic [31:0] inst_o;
   logic        fetchValid_o;

   if_fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk          (clk),
      .rst          (rst),
      .pcWrite      (pcWrite),
      .branchTaken  (branchTaken),
      .branchTarget (branchTarget),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .pc_o         (pc_o),
      .pcPlusFour_o (pcPlusFour_o),
      .inst_o       (inst_o),
      .fetchValid_o (fetchValid_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // model of the fetch unit, in transaction terms
   logic [31:0] m_pc, m_ppc, m_ppf, m_inst;
   bit          m_busy, m_stale, m_val;
   // memory model
   bit          mem_pend;
   logic [31:0] mem_addr;
   int unsigned mem_cnt;
   int unsigned lat_min, lat_max, ready_pct, spur_pct;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_update();
      bit req, acc, resp;
      if (rst) begin
         m_pc = RST_PC; m_busy = 0; m_stale = 0; m_val = 0;
         m_ppc = '0; m_ppf = '0; m_inst = '0;
         mem_pend = 0;
      end else begin
         req  = !m_busy && !m_val;
         acc  = req && imem_ready;
         resp = m_busy && imem_rvalid;
         if (acc) begin
            mem_pend = 1; mem_addr = m_pc; mem_cnt = $urandom_range(lat_max, lat_min);
         end
         if (resp) mem_pend = 0;
         if (branchTaken) begin
            if (acc) begin m_busy = 1; m_stale = 1; end
            else if (resp) begin m_busy = 0; m_stale = 0; end
            else if (m_busy) m_stale = 1;
            m_val = 0; m_inst = '0; m_ppc = '0; m_ppf = '0;
            m_pc = branchTarget & ~32'd3;
         end else if (acc) begin
            m_busy = 1;
         end else if (resp) begin
            m_busy = 0;
            if (m_stale) m_stale = 0;
            else begin
               m_val = 1; m_ppc = m_pc; m_ppf = m_pc + 32'd4;
               m_inst = mem_word(m_pc); m_pc = m_pc + 32'd4;
            end
         end else if (m_val && pcWrite) begin
            m_val = 0; m_inst = '0;
         end
      end
   endtask

   task automatic compare_model();
      bit exp_req;
      exp_req = !rst && !m_busy && !m_val;
      chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
      if (exp_req) chk("imem_addr", imem_addr, m_pc);
      chk("pc_o", pc_o, m_ppc);
      chk("pcPlusFour_o", pcPlusFour_o, m_ppf);
      chk("inst_o", inst_o, m_inst);
      chk("fetchValid_o", {31'd0, fetchValid_o}, {31'd0, m_val});
   endtask

   task automatic drive_mem();
      imem_ready = ($urandom_range(99) < ready_pct);
      if (mem_pend) begin
         if (mem_cnt == 0) begin
            imem_rvalid = 1'b1; imem_rdata = mem_word(mem_addr);
         end else begin
            mem_cnt--; imem_rvalid = 1'b0; imem_rdata = $urandom;
         end
      end else begin
         imem_rvalid = ($urandom_range(99) < spur_pct);
         imem_rdata  = $urandom;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare_model();
      drive_mem();
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!fetchValid_o && n < 20) begin
         step();
         n++;
      end
      chk(name, {31'd0, fetchValid_o}, 32'd1);
   endtask

   task automatic pin_pres(input string name, input logic [31:0] pc, input logic [31:0] ppf,
                           input logic [31:0] inst);
      wait_valid({name, "_timeout"});
      chk({name, "_pc"}, pc_o, pc);
      chk({name, "_ppf"}, pcPlusFour_o, ppf);
      chk({name, "_inst"}, inst_o, inst);
   endtask

   initial begin
      rst = 1'b1; pcWrite = 1'b1; branchTaken = 1'b0; branchTarget = '0;
      imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      m_pc = RST_PC; m_ppc = '0; m_ppf = '0; m_inst = '0;
      m_busy = 0; m_stale = 0; m_val = 0; mem_pend = 0; mem_addr = '0; mem_cnt = 0;
      lat_min = 0; lat_max = 0; ready_pct = 0; spur_pct = 0;

      // reset values, then memory not ready for three cycles
      @(negedge clk);
      step();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, fetchValid_o}, 32'd0);
      chk("rst_pc", pc_o, 32'd0);
      chk("rst_inst", inst_o, 32'd0);
      rst = 1'b0;
      #1;
      chk("first_req", {31'd0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'hFFFF_FFF4);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("notready_req", {31'd0, imem_req}, 32'd1);
         chk("notready_addr", imem_addr, 32'hFFFF_FFF4);
      end
      ready_pct = 100;
      imem_ready = 1'b1;

      // back-to-back fetches across the 32-bit wrap
      pin_pres("p0", 32'hFFFF_FFF4, 32'hFFFF_FFF8, 32'hA5A5_FFF4);
      step();
      pin_pres("p1", 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'hA5A5_FFF8);
      step();
      pin_pres("p2", 32'hFFFF_FFFC, 32'h0000_0000, 32'hA5A5_FFFC);
      step();
      pin_pres("p3", 32'h0000_0000, 32'h0000_0004, 32'h5A5A_0000);

      // stall holds the presented instruction and suppresses requests
      pcWrite = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_valid", {31'd0, fetchValid_o}, 32'd1);
         chk("stall_pc", pc_o, 32'd0);
         chk("stall_req", {31'd0, imem_req}, 32'd0);
      end
      pcWrite = 1'b1;
      step();
      chk("after_stall_req", {31'd0, imem_req}, 32'd1);
      chk("after_stall_addr", imem_addr, 32'h0000_0004);

      // redirect while a fetch is outstanding: stale response must be dropped
      lat_min = 2; lat_max = 2;
      step();
      branchTaken = 1'b1; branchTarget = 32'h0000_0103;
      step();
      branchTaken = 1'b0;
      chk("redir_valid", {31'd0, fetchValid_o}, 32'd0);
      chk("redir_inst", inst_o, 32'd0);
      chk("redir_pc", pc_o, 32'd0);
      pin_pres("p_redir", 32'h0000_0100, 32'h0000_0104, 32'h5A5A_0100);

      // redirect coincident with acceptance of the old-PC request
      lat_min = 0; lat_max = 0;
      step();
      branchTaken = 1'b1; branchTarget = 32'h0000_0080;
      step();
      branchTaken = 1'b0;
      pin_pres("p_acc_redir", 32'h0000_0080, 32'h0000_0084, 32'h5A5A_0080);

      // reset while waiting for a response
      lat_min = 2; lat_max = 2;
      step();
      step();
      rst = 1'b1;
      step();
      chk("midrst_req", {31'd0, imem_req}, 32'd0);
      chk("midrst_valid", {31'd0, fetchValid_o}, 32'd0);
      chk("midrst_pc", pc_o, 32'd0);
      chk("midrst_ppf", pcPlusFour_o, 32'd0);
      chk("midrst_inst", inst_o, 32'd0);
      rst = 1'b0;
      #1;
      chk("midrst_after_req", {31'd0, imem_req}, 32'd1);
      chk("midrst_after_addr", imem_addr, 32'hFFFF_FFF4);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         if (i % 200 == 0) begin
            lat_min   = $urandom_range(1, 0);
            lat_max   = lat_min + $urandom_range(4, 0);
            ready_pct = $urandom_range(100, 20);
            spur_pct  = $urandom_range(30, 0);
         end
         rst         = ($urandom_range(299) == 0);
         branchTaken = !rst && ($urandom_range(7) == 0);
         if ($urandom_range(3) == 0) branchTarget = 32'hFFFF_FFF0 | 32'($urandom_range(15));
         else branchTarget = $urandom;
         pcWrite = ($urandom_range(99) < 65);
         step();
      end
      rst = 1'b0; branchTaken = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage: the producer side of the IF/ID pipeline register.
- Owns the fetch PC and talks to the instruction memory through a request/response handshake with variable latency.
- Presents pc_o, pcPlusFour_o and inst_o to IF/ID, which captures them when its enable (pcWrite) is high.
- Handles stalls from the hazard unit and branch redirects, including discarding an in-flight fetch on a redirect.

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset; bits [1:0] must be 0.

Ports:
- clk  input  1  clock, all state on posedge.
- rst  input  1  synchronous, active-high reset.
- pcWrite  input  1  hazard-unit enable, same signal that drives the IF/ID enable; 1 means the presented instruction is consumed this cycle.
- branchTaken  input  1  one-cycle redirect pulse, coincident with IF_Flush.
- branchTarget  input  32  redirect address; bits [1:0] ignored and forced to 0.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address.
- imem_ready  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  response data valid.
- imem_rdata  input  32  instruction word.
- pc_o  output  32  PC of the presented instruction.
- pcPlusFour_o  output  32  pc_o + 4.
- inst_o  output  32  presented instruction; 0 when none is presented (bubble).
- fetchValid_o  output  1  inst_o holds a real instruction.

Behaviour:
Internal state:
- fetchPc (32b), discard flag.
- FSM states: S_REQ, S_WAIT, S_HOLD.

Reset (rst=1 at posedge):
- fetchPc=RESET_PC, state=S_REQ, discard=0.
- pc_o=0, pcPlusFour_o=0, inst_o=0, fetchValid_o=0.
- imem_req is 0 while rst is high.

Outputs and protocol:
- imem_req = (state==S_REQ) && !rst.
- imem_addr = fetchPc, held stable while imem_req && !imem_ready. The only exception is a redirect (below).
- At most one outstanding request.
- The memory asserts imem_rvalid no earlier than the cycle after acceptance.
- imem_rvalid is ignored outside S_WAIT.

S_REQ:
- imem_ready=1 -> S_WAIT.
- Otherwise stay in S_REQ.

S_WAIT:
- imem_rvalid=1 and discard=1 -> clear discard, go to S_REQ; outputs unchanged.
- imem_rvalid=1 and discard=0 -> at the next edge:
  - inst_o=imem_rdata, pc_o=fetchPc, pcPlusFour_o=fetchPc+4, fetchValid_o=1;
  - fetchPc=fetchPc+4;
  - go to S_HOLD.
- Fetch latency: request accepted at edge N, rvalid at edge N+k (k>=1), instruction visible after edge N+k.

S_HOLD:
- Outputs held.
- pcWrite=1 -> at the next edge: fetchValid_o=0, inst_o=0, pc_o/pcPlusFour_o unchanged, go to S_REQ.
- pcWrite=0 (stall) -> stay in S_HOLD indefinitely.
- pcWrite is a don't-care in S_REQ and S_WAIT. If IF/ID captures in those states it captures inst_o=0, fetchValid_o=0, which is a bubble.

Redirect (branchTaken=1) has the highest priority over pcWrite and rvalid. At the next edge:
- fetchPc=branchTarget & ~3.
- fetchValid_o=0, inst_o=0, pc_o=0, pcPlusFour_o=0.

Redirect transitions by state:
- S_HOLD -> S_REQ.
- S_REQ with imem_ready=0 -> stay in S_REQ; imem_addr switches to the target on the following cycle.
- S_REQ with imem_ready=1 -> the old-PC request was accepted; set discard=1, go to S_WAIT.
- S_WAIT with imem_rvalid=0 -> set discard=1, stay in S_WAIT.
- S_WAIT with imem_rvalid=1 -> drop the data, discard=0, go to S_REQ.
- A redirect while discard is already 1 -> discard stays 1, fetchPc takes the newest target.

Arithmetic and boundaries:
- fetchPc+4 wraps modulo 2^32: 32'hFFFFFFFC -> 0, and pcPlusFour_o=0 in that case.
- Reset mid-operation (any state) -> the reset values above. The memory shares rst and drops any outstanding response.
- Throughput: at best one instruction per 3 cycles (REQ, WAIT, HOLD).

Test Plan:
- Reset, RESET_PC=0, imem_ready=1 always, rvalid one cycle after acceptance, pcWrite=1 -> imem_addr sequence 0,4,8. pc_o/inst_o present 0/rdata0, then 4/rdata1, each with fetchValid_o=1 for exactly one cycle. pcPlusFour_o=pc_o+4.
- imem_ready held 0 for 3 cycles at addr 8 -> imem_req=1 and imem_addr=8 stable for all 3 cycles, no fetchValid_o. Then accepted; rvalid after 4 cycles; inst presented with pc_o=8.
- Instruction at pc 0x10 presented, pcWrite=0 for 5 cycles -> pc_o=0x10, inst_o and fetchValid_o=1 unchanged, imem_req=0. pcWrite=1 -> next request addr 0x14.
- Redirect in S_WAIT (request for 0x20 outstanding), branchTaken=1, branchTarget=0x103 -> fetchValid_o=0, inst_o=0. The stale rvalid for 0x20 is not presented. Next imem_addr=0x100, then pc_o=0x100.
- Redirect in the same cycle as imem_ready=1 for addr 0x40, target 0x80 -> discard set. The response for 0x40 is dropped; next request addr 0x80.
- RESET_PC=32'hFFFFFFFC -> first presentation pc_o=FFFFFFFC, pcPlusFour_o=0, next imem_addr=0. Asserting rst in S_WAIT -> all outputs 0, imem_req=0 during reset; request to RESET_PC after reset is released.
